// File: rtl/pixel_probe_pkg.sv
// pixel_probe_pkg: shared probe state encoding, framebuffer geometry and address helper
package pixel_probe_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} probe_state_t;
    localparam int H_RES_DEF = 160;
    localparam int V_RES_DEF = 120;
    localparam int ADDR_W = 15;
    localparam logic [4:0] MAX_HITS = 5'd16;
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [8:0] px, input logic [7:0] py, input logic [ADDR_W-1:0] h);
        return ADDR_W'(py) * h + ADDR_W'(px);
    endfunction
endpackage

// File: rtl/pixel_probe_if.sv
// pixel_probe_if: probe request/result handshake plus background-memory read port
interface pixel_probe_if;
    import pixel_probe_pkg::*;
    logic req;
    logic [7:0] x;
    logic [6:0] y;
    logic [1:0] size;
    logic busy;
    logic done;
    logic hit;
    logic [4:0] hit_count;
    logic [7:0] hit_x;
    logic [6:0] hit_y;
    logic [ADDR_W-1:0] mem_addr;
    logic mem_rden;
    logic [2:0] mem_q;
    modport master (output req, x, y, size, mem_q, input busy, done, hit, hit_count, hit_x, hit_y, mem_addr, mem_rden);
    modport slave (input req, x, y, size, mem_q, output busy, done, hit, hit_count, hit_x, hit_y, mem_addr, mem_rden);
endinterface

// File: rtl/pixel_probe_addr_gen.sv
// probe_addr_gen: walks the square footprint in raster order and registers the read address per pixel
module probe_addr_gen import pixel_probe_pkg::*; #(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic step,
    input  logic stop,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [1:0] size,
    output logic [7:0] px,
    output logic [6:0] py,
    output logic oob,
    output logic last,
    output logic [ADDR_W-1:0] mem_addr,
    output logic mem_rden
);
    localparam logic [8:0] H_MAX = 9'(H_RES);
    localparam logic [7:0] V_MAX = 8'(V_RES);
    localparam logic [ADDR_W-1:0] H_W = ADDR_W'(H_RES);
    logic [7:0] bx_q, bx_d;
    logic [6:0] by_q, by_d;
    logic [1:0] sz_q, sz_d, dx_q, dx_d, dy_q, dy_d, ndx, ndy;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic rden_q, rden_d;
    logic [8:0] cx, nx;
    logic [7:0] cy, ny;
    always_comb begin
        cx = {1'b0, bx_q} + {7'd0, dx_q};
        cy = {1'b0, by_q} + {6'd0, dy_q};
        px = cx[7:0];
        py = cy[6:0];
        oob = !(cx < H_MAX && cy < V_MAX);
        last = dx_q == sz_q && dy_q == sz_q;
        ndx = dx_q == sz_q ? 2'd0 : dx_q + 2'd1;
        ndy = dx_q == sz_q ? dy_q + 2'd1 : dy_q;
        nx = start ? {1'b0, x} : {1'b0, bx_q} + {7'd0, ndx};
        ny = start ? {1'b0, y} : {1'b0, by_q} + {6'd0, ndy};
        bx_d = start ? x : bx_q;
        by_d = start ? y : by_q;
        sz_d = start ? size : sz_q;
        dx_d = start ? 2'd0 : step ? ndx : dx_q;
        dy_d = start ? 2'd0 : step ? ndy : dy_q;
        addr_d = start || step ? pix_addr(nx, ny, H_W) : addr_q;
        rden_d = start || step ? (nx < H_MAX && ny < V_MAX) : stop ? 1'b0 : rden_q;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            bx_q <= '0;
            by_q <= '0;
            sz_q <= '0;
            dx_q <= '0;
            dy_q <= '0;
            addr_q <= '0;
            rden_q <= 1'b0;
        end else begin
            bx_q <= bx_d;
            by_q <= by_d;
            sz_q <= sz_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
            addr_q <= addr_d;
            rden_q <= rden_d;
        end
    assign mem_addr = addr_q;
    assign mem_rden = rden_q;
endmodule

// File: rtl/pixel_probe.sv
// pixel_probe: scans a square footprint in background memory and reports obstacle pixels
module pixel_probe import pixel_probe_pkg::*; #(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF,
    parameter logic [2:0] WALL_COLOR = 3'b000
) (
    input logic clk,
    input logic reset,
    pixel_probe_if.slave p
);
    probe_state_t state_q, state_d;
    logic busy_q, busy_d, done_q, done_d, hit_q, hit_d;
    logic [4:0] cnt_q, cnt_d;
    logic [7:0] hx_q, hx_d, spx_q, spx_d, px;
    logic [6:0] hy_q, hy_d, spy_q, spy_d, py;
    logic sv_q, sv_d, so_q, so_d;
    logic start, scan, last, oob, obst;
    probe_addr_gen #(.H_RES(H_RES), .V_RES(V_RES)) u_gen (
        .clk(clk), .reset(reset), .start(start), .step(scan && !last), .stop(scan && last),
        .x(p.x), .y(p.y), .size(p.size), .px(px), .py(py), .oob(oob), .last(last),
        .mem_addr(p.mem_addr), .mem_rden(p.mem_rden)
    );
    // the s*_q stage tracks the pixel whose mem_q arrives this cycle
    always_comb begin
        start = state_q == IDLE && p.req;
        scan = state_q == SCAN;
        state_d = start ? SCAN : scan && last ? DRAIN : state_q == DRAIN ? DONE : state_q == DONE ? IDLE : state_q;
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
        sv_d = scan;
        so_d = oob;
        spx_d = px;
        spy_d = py;
        obst = sv_q && (so_q || p.mem_q == WALL_COLOR);
        hit_d = start ? 1'b0 : hit_q || obst;
        hx_d = start ? 8'd0 : obst && !hit_q ? spx_q : hx_q;
        hy_d = start ? 7'd0 : obst && !hit_q ? spy_q : hy_q;
        cnt_d = start ? 5'd0 : obst && cnt_q != MAX_HITS ? cnt_q + 5'd1 : cnt_q;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hit_q <= 1'b0;
            cnt_q <= '0;
            hx_q <= '0;
            hy_q <= '0;
            sv_q <= 1'b0;
            so_q <= 1'b0;
            spx_q <= '0;
            spy_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q <= busy_d;
            done_q <= done_d;
            hit_q <= hit_d;
            cnt_q <= cnt_d;
            hx_q <= hx_d;
            hy_q <= hy_d;
            sv_q <= sv_d;
            so_q <= so_d;
            spx_q <= spx_d;
            spy_q <= spy_d;
        end
    assign p.busy = busy_q;
    assign p.done = done_q;
    assign p.hit = hit_q;
    assign p.hit_count = cnt_q;
    assign p.hit_x = hx_q;
    assign p.hit_y = hy_q;
endmodule

// File: tb/tb_pixel_probe.sv
// tb_pixel_probe: randomized probes checked against a footprint-walking reference model
module tb_pixel_probe;
    localparam int H = 160;
    localparam int V = 120;
    localparam logic [2:0] WALL = 3'b000;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [2:0] mem [0:H*V-1];
    int n_chk = 0;
    int n_err = 0;
    pixel_probe_if p();
    pixel_probe dut (.clk(clk), .reset(reset), .p(p.slave));
    always #5 clk = ~clk;
    always @(posedge clk) if (p.mem_rden) p.mem_q <= mem[p.mem_addr];
    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic model(input int xi, input int yi, input int si, output int h, output int cnt,
                         output int hx, output int hy, output int rd, output int fa);
        h = 0; cnt = 0; hx = 0; hy = 0; rd = 0; fa = -1;
        for (int dy = 0; dy <= si; dy++)
            for (int dx = 0; dx <= si; dx++) begin
                int px, py;
                bit ob;
                px = xi + dx;
                py = yi + dy;
                ob = px >= H || py >= V;
                if (!ob) begin
                    rd++;
                    if (fa < 0) fa = py * H + px;
                end
                if (!ob && mem[py * H + px] != WALL) continue;
                if (cnt == 0) begin hx = px % 256; hy = py % 128; h = 1; end
                if (cnt < 16) cnt++;
            end
    endtask
    task automatic fill(input int wall_pct);
        for (int i = 0; i < H * V; i++)
            mem[i] = ($urandom_range(0, 99) < wall_pct) ? WALL : 3'($urandom_range(1, 7));
    endtask
    task automatic probe(input int xi, input int yi, input int si, input bit pulse_again);
        int h, cnt, hx, hy, rd, fa, lat, nrd, first;
        bit got;
        model(xi, yi, si, h, cnt, hx, hy, rd, fa);
        @(negedge clk);
        p.x = 8'(xi); p.y = 7'(yi); p.size = 2'(si); p.req = 1'b1;
        @(negedge clk);
        p.req = 1'b0;
        check("busy_rise", p.busy, 1);
        lat = 0; nrd = 0; first = -1; got = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            if (c > 1) @(negedge clk);
            lat = c;
            if (pulse_again) p.req = (c == 5);
            if (p.mem_rden) begin
                nrd++;
                if (first < 0) first = int'(p.mem_addr);
            end
            if (p.done) got = 1;
        end
        p.req = 1'b0;
        check("done_seen", int'(got), 1);
        check("latency", lat, (si + 1) * (si + 1) + 2);
        check("hit", p.hit, h);
        check("hit_count", p.hit_count, cnt);
        check("hit_x", p.hit_x, hx);
        check("hit_y", p.hit_y, hy);
        check("rden_count", nrd, rd);
        check("first_addr", first, fa);
        @(negedge clk);
        check("done_width", p.done, 0);
        check("busy_fall", p.busy, 0);
        check("hold_count", p.hit_count, cnt);
        check("hold_hit_x", p.hit_x, hx);
    endtask
    initial begin
        int last_done, ndone, run;
        p.req = 1'b0; p.x = '0; p.y = '0; p.size = '0;
        fill(0);
        repeat (2) @(negedge clk);
        check("rst_busy", p.busy, 0);
        check("rst_done", p.done, 0);
        check("rst_addr", p.mem_addr, 0);
        check("rst_rden", p.mem_rden, 0);
        reset = 1'b0;
        probe(10, 20, 3, 0);
        mem[3211] = WALL;
        probe(10, 20, 1, 0);
        mem[3211] = 3'b111;
        probe(158, 118, 3, 0);
        probe(10, 20, 3, 1);
        @(negedge clk);
        p.x = 8'd30; p.y = 7'd40; p.size = 2'd3; p.req = 1'b1;
        @(negedge clk);
        p.req = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", p.busy, 0);
        check("abort_rden", p.mem_rden, 0);
        check("abort_addr", p.mem_addr, 0);
        check("abort_count", p.hit_count, 0);
        @(negedge clk);
        reset = 1'b0;
        check("abort_done", p.done, 0);
        probe(0, 0, 0, 0);
        fill(15);
        for (int i = 0; i < 30; i++)
            probe($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 3), 0);
        for (int i = 0; i < 6; i++)
            probe($urandom_range(H - 3, H + 2), $urandom_range(V - 3, V + 2), $urandom_range(0, 3), 0);
        @(negedge clk);
        p.x = 8'd5; p.y = 7'd5; p.size = 2'd0; p.req = 1'b1;
        last_done = -1; ndone = 0; run = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (p.done) begin
                if (last_done >= 0) check("done_period", i - last_done, 4);
                last_done = i;
                ndone++;
            end
            if (!p.busy) run++;
            else if (run > 0) begin
                check("busy_gap", run, 1);
                run = 0;
            end
        end
        p.req = 1'b0;
        check("held_dones", ndone, 5);
        repeat (5) @(negedge clk);
        check("final_idle", p.busy, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
